wb_select_pipe: RTL and testbench
=================================

// Module: wb_select_pipe
// PURPOSE
//  Parametrised write-back source selector for the register-file data path.
//  Picks one of NUM_IN data sources or a fixed constant, and extracts byte/halfword
//  load data with sign or zero extension when the memory source is selected.
//  Registers the result behind a 2-entry valid/ready skid buffer, so the
//  write-back stage can stall without dropping data.
//  Sits between the memory-data/ALU/shift result registers and the register-file write port.
// PARAMETERS
//  WIDTH     32   data width in bits (>=32)
//  NUM_IN    7    number of external data sources (>=2)
//  CONST_VAL 277  value driven when sel >= NUM_IN
//  MEM_SRC   1    index of the source that receives load-size extraction (< NUM_IN)
//  SEL_W     derived localparam = $clog2(NUM_IN+1); not overridable
// PORTS
//  clk          in   1            rising-edge clock
//  reset        in   1            asynchronous, active-low reset
//  src_data     in   NUM_IN*WIDTH packed sources; source i = src_data[i*WIDTH +: WIDTH]
//  sel          in   SEL_W        source select
//  ld_size      in   2            00 word, 01 half, 10 byte, 11 reserved
//  ld_unsigned  in   1            1 = zero-extend, 0 = sign-extend (half/byte only)
//  byte_off     in   2            address[1:0] of the load
//  in_valid     in   1            input beat valid
//  in_ready     out  1            buffer can accept a beat
//  out_valid    out  1            out_data valid
//  out_ready    in   1            consumer accepts the beat
//  out_data     out  WIDTH        selected/extended data
//  out_err      out  1            beat carried a reserved ld_size or a misaligned half
// BEHAVIOUR
//  - Select: sel < NUM_IN -> source[sel]; sel >= NUM_IN -> CONST_VAL (zero-extended to WIDTH).
//  - Extraction (only when sel == MEM_SRC):
//      word: pass through.
//      half: byte_off[1] picks bits [31:16] (1) or [15:0] (0); byte_off[0]=1 -> out_err=1, data still extracted.
//      byte: byte_off picks byte 0..3.
//      Extension is per ld_unsigned.
//      ld_size=11: data passed as word, out_err=1.
//  - ld_size, ld_unsigned and byte_off are ignored for every other source; out_err=0 for those sources.
//  - Handshake: a beat transfers in when in_valid & in_ready, and out when out_valid & out_ready.
//    Data must not change while out_valid=1 and out_ready=0.
//  - FSM on the occupancy state: EMPTY -> ONE on push;
//      ONE -> EMPTY on pop without push; ONE -> TWO on push without pop;
//      ONE stays ONE on push with pop (new beat replaces old, 1 beat/cycle);
//      TWO -> ONE on pop. TWO never pushes, because in_ready=0.
//  - in_ready = (state != TWO); it is driven from a register, with no combinational path from out_ready.
//  - out_valid = (state != EMPTY). out_data/out_err come from the head entry.
//    The skid entry moves to the head on a pop from TWO.
//  - Latency: a beat accepted in cycle N is visible on out_data in cycle N+1.
//    Throughput is 1 beat/cycle when out_ready stays high.
//  - Reset (async assert, sync deassert by top):
//      state=EMPTY, out_valid=0, in_ready=1, out_data=0, out_err=0, both entries cleared.
//    A reset mid-operation drops every buffered beat.
//  - in_valid=0 with any sel -> no state change. X on unused inputs must not propagate when in_valid=0.
// STRUCTURE
//  - Shared package wb_pkg:
//      LD_WORD/LD_HALF/LD_BYTE/LD_RSVD size codes;
//      the default CONST_VAL (277);
//      state encoding EMPTY=2'd0, ONE=2'd1, TWO=2'd2.
//  - One sub-module, load_extract: combinational extraction, (data, ld_size, ld_unsigned, byte_off) -> (data, err).
//  - Selection and skid FSM stay in this module.
// TESTING
//  1. Reset low with in_valid=1 -> out_valid=0, in_ready=1, out_data=0. Release: first beat appears 1 cycle after acceptance.
//  2. sel=3, src3=0xDEADBEEF, out_ready=1 -> out_data=0xDEADBEEF next cycle. sel=7 (NUM_IN=7) -> out_data=277 (0x115).
//  3. sel=MEM_SRC, word 0x80FF7F01:
//      byte, off=1, signed -> 0x0000007F; off=3, signed -> 0xFFFFFF80;
//      half, off=2, unsigned -> 0x000080FF; half, off=1 -> out_err=1.
//  4. out_ready=0, push A,B -> in_ready=0 after B; C held off.
//     Raise out_ready -> A, B, C emerge in order, no loss or duplication.
//  5. Streaming 100 random beats with random out_ready -> scoreboard matches in order; no beat lost when push and pop coincide in ONE.
//  6. Assert reset while state=TWO -> out_valid=0 immediately (async). Beats pushed after release are the only ones seen.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the write-back select pipe: load-size codes, the default
// constant source value and the skid-buffer occupancy encoding.
package wb_pkg;

   typedef enum logic [1:0] {
      LD_WORD = 2'b00,
      LD_HALF = 2'b01,
      LD_BYTE = 2'b10,
      LD_RSVD = 2'b11
   } ld_size_e;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_e;

   localparam int unsigned CONST_VAL_DEFAULT = 277;

   // Sign- or zero-extend a narrow field into the low bits of a 32-bit word.
   function automatic logic [31:0] ext16(input logic [15:0] v, input logic uns);
      return {{16{~uns & v[15]}}, v};
   endfunction

   function automatic logic [31:0] ext8(input logic [7:0] v, input logic uns);
      return {{24{~uns & v[7]}}, v};
   endfunction

endpackage

// File: rtl/wb_select_pipe_load_extract.sv
// Combinational load-data extraction: picks the addressed byte/halfword of the
// memory word and extends it; flags reserved sizes and misaligned halfwords.
module load_extract
   import wb_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] data_i,
   input  logic [1:0]       ld_size_i,
   input  logic             ld_unsigned_i,
   input  logic [1:0]       byte_off_i,
   output logic [WIDTH-1:0] data_o,
   output logic             err_o
);

   logic [15:0] half_v;
   logic [7:0]  byte_v;
   logic [31:0] ext_v;

   always_comb begin
      half_v = byte_off_i[1] ? data_i[31:16] : data_i[15:0];
      byte_v = data_i[{byte_off_i, 3'b000} +: 8];
      ext_v  = data_i[31:0];
      data_o = data_i;
      err_o  = 1'b0;
      case (ld_size_e'(ld_size_i))
         LD_HALF: begin
            ext_v  = ext16(half_v, ld_unsigned_i);
            // A misaligned half is still extracted so the trap handler sees real data.
            err_o  = byte_off_i[0];
            data_o = {{(WIDTH-32){ext_v[31]}}, ext_v};
         end
         LD_BYTE: begin
            ext_v  = ext8(byte_v, ld_unsigned_i);
            data_o = {{(WIDTH-32){ext_v[31]}}, ext_v};
         end
         LD_RSVD: err_o = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/wb_select_pipe.sv
// Write-back source selector with load extraction, registered behind a
// 2-entry valid/ready skid buffer so the register-file port may stall.
module wb_select_pipe
   import wb_pkg::*;
#(
   parameter  int          WIDTH     = 32,
   parameter  int          NUM_IN    = 7,
   parameter  int unsigned CONST_VAL = CONST_VAL_DEFAULT,
   parameter  int          MEM_SRC   = 1,
   localparam int          SEL_W     = $clog2(NUM_IN + 1)
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [NUM_IN*WIDTH-1:0] src_data_i,
   input  logic [SEL_W-1:0]        sel_i,
   input  logic [1:0]              ld_size_i,
   input  logic                    ld_unsigned_i,
   input  logic [1:0]              byte_off_i,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [WIDTH-1:0]        out_data_o,
   output logic                    out_err_o
);

   localparam logic [WIDTH-1:0] CONST_W = WIDTH'(CONST_VAL);

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             err;
   } entry_t;

   occ_e             state_q, state_d;
   logic             in_ready_q;
   entry_t           head_q, skid_q;
   entry_t           new_entry;
   logic [WIDTH-1:0] sel_data;
   logic [WIDTH-1:0] ext_data;
   logic             ext_err;
   logic             push, pop;

   always_comb begin
      sel_data = CONST_W;
      for (int i = 0; i < NUM_IN; i++) begin
         if (sel_i == SEL_W'(i)) sel_data = src_data_i[i*WIDTH +: WIDTH];
      end
   end

   load_extract #(.WIDTH(WIDTH)) u_extract (
      .data_i        (src_data_i[MEM_SRC*WIDTH +: WIDTH]),
      .ld_size_i     (ld_size_i),
      .ld_unsigned_i (ld_unsigned_i),
      .byte_off_i    (byte_off_i),
      .data_o        (ext_data),
      .err_o         (ext_err)
   );

   always_comb begin
      new_entry.data = sel_data;
      new_entry.err  = 1'b0;
      if (sel_i == SEL_W'(MEM_SRC)) begin
         new_entry.data = ext_data;
         new_entry.err  = ext_err;
      end
   end

   // Handshakes use the registered ready only, so out_ready never reaches in_ready.
   assign push = in_valid_i & in_ready_q;
   assign pop  = (state_q != EMPTY) & out_ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != TWO);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: if (push) state_d = ONE;
         ONE: begin
            if (pop && !push)      state_d = EMPTY;
            else if (push && !pop) state_d = TWO;
         end
         TWO:     if (pop) state_d = ONE;
         default: state_d = EMPTY;
      endcase
   end

   always_comb begin
      out_valid_o = (state_q != EMPTY);
      in_ready_o  = in_ready_q;
      out_data_o  = head_q.data;
      out_err_o   = head_q.err;
   end

   // Only pushes load from the inputs, so idle-cycle garbage never reaches an entry.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_q <= '0;
         skid_q <= '0;
      end else begin
         if (push && (state_q == EMPTY || (state_q == ONE && pop)))
            head_q <= new_entry;
         else if (pop && state_q == TWO)
            head_q <= skid_q;
         if (push && !pop && state_q == ONE)
            skid_q <= new_entry;
      end
   end

endmodule

// File: tb/tb_wb_select_pipe.sv
// Directed and random-stream bench for wb_select_pipe with default parameters.
module tb_wb_select_pipe;

   localparam int WIDTH  = 32;
   localparam int NUM_IN = 7;
   localparam int SEL_W  = 3;

   logic                    clk, rst_n;
   logic [NUM_IN*WIDTH-1:0] src;
   logic [SEL_W-1:0]        sel;
   logic [1:0]              ld_size, off;
   logic                    ld_uns, in_valid, in_ready, out_valid, out_ready, out_err;
   logic [WIDTH-1:0]        out_data;

   int checks = 0;
   int errors = 0;

   wb_select_pipe dut (
      .clk_i(clk), .rst_ni(rst_n), .src_data_i(src), .sel_i(sel),
      .ld_size_i(ld_size), .ld_unsigned_i(ld_uns), .byte_off_i(off),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .out_valid_o(out_valid),
      .out_ready_i(out_ready), .out_data_o(out_data), .out_err_o(out_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [SEL_W-1:0] s, input logic [31:0] d,
                        input logic [1:0] sz, input logic u, input logic [1:0] o);
      sel = s;
      if (int'(s) < NUM_IN) src[int'(s)*WIDTH +: WIDTH] = d;
      ld_size = sz; ld_uns = u; off = o; in_valid = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; src = '1; sel = 3'd3; ld_size = 2'b00; ld_uns = 1'b0; off = 2'b00;
      in_valid = 1'b1; out_ready = 1'b1;
      repeat (3) step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
      checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data got %h exp 0", out_data); end
      drive(3'd3, 32'h1234_5678, 2'b00, 1'b0, 2'b00);
      #3 rst_n = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rel_no_early got %b exp 0", out_valid); end
      step();
      checks++; if (out_valid !== 1'b1 || out_data !== 32'h1234_5678)
         begin errors++; $display("FAIL first_beat got v=%b %h exp v=1 12345678", out_valid, out_data); end
      in_valid = 1'b0;
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL first_drain got %b exp 0", out_valid); end
   endtask

   task automatic test_select();
      out_ready = 1'b1;
      drive(3'd3, 32'hDEAD_BEEF, 2'b00, 1'b0, 2'b00); step();
      checks++; if (out_data !== 32'hDEAD_BEEF || out_err !== 1'b0)
         begin errors++; $display("FAIL sel3 got %h/%b exp deadbeef/0", out_data, out_err); end
      drive(3'd7, 32'h0, 2'b00, 1'b0, 2'b00); step();
      checks++; if (out_data !== 32'h0000_0115 || out_err !== 1'b0)
         begin errors++; $display("FAIL sel_const got %h/%b exp 00000115/0", out_data, out_err); end
      drive(3'd2, 32'h80FF_7F01, 2'b10, 1'b0, 2'b11); step();
      checks++; if (out_data !== 32'h80FF_7F01 || out_err !== 1'b0)
         begin errors++; $display("FAIL nonmem_byte got %h/%b exp 80ff7f01/0", out_data, out_err); end
      drive(3'd6, 32'h0BAD_F00D, 2'b11, 1'b1, 2'b01); step();
      checks++; if (out_data !== 32'h0BAD_F00D || out_err !== 1'b0)
         begin errors++; $display("FAIL nonmem_rsvd got %h/%b exp 0badf00d/0", out_data, out_err); end
      in_valid = 1'b0; sel = 3'd5;
      repeat (3) step();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
         begin errors++; $display("FAIL idle_no_push got v=%b r=%b exp v=0 r=1", out_valid, in_ready); end
   endtask

   task automatic test_extract();
      logic [1:0]  t_sz  [9] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10, 2'b00, 2'b11, 2'b10};
      logic        t_u   [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [1:0]  t_off [9] = '{2'd1, 2'd3, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3, 2'd0, 2'd0};
      logic [31:0] t_exp [9] = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_80FF, 32'h0000_7F01,
                                 32'hFFFF_80FF, 32'h0000_00FF, 32'h80FF_7F01, 32'h80FF_7F01,
                                 32'h0000_0001};
      logic        t_err [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         drive(3'd1, 32'h80FF_7F01, t_sz[i], t_u[i], t_off[i]);
         step();
         checks++;
         if (out_data !== t_exp[i] || out_err !== t_err[i] || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL extract[%0d] got %h/%b v=%b exp %h/%b v=1", i, out_data, out_err, out_valid, t_exp[i], t_err[i]);
         end
      end
      in_valid = 1'b0;
      step();
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      drive(3'd0, 32'hA, 2'b00, 1'b0, 2'b00); step();
      checks++; if (in_ready !== 1'b1 || out_data !== 32'hA)
         begin errors++; $display("FAIL bp_one got r=%b %h exp r=1 a", in_ready, out_data); end
      drive(3'd0, 32'hB, 2'b00, 1'b0, 2'b00); step();
      checks++; if (in_ready !== 1'b0 || out_data !== 32'hA)
         begin errors++; $display("FAIL bp_two got r=%b %h exp r=0 a", in_ready, out_data); end
      drive(3'd0, 32'hC, 2'b00, 1'b0, 2'b00); step();
      checks++; if (in_ready !== 1'b0 || out_data !== 32'hA || out_valid !== 1'b1)
         begin errors++; $display("FAIL bp_hold got r=%b v=%b %h exp r=0 v=1 a", in_ready, out_valid, out_data); end
      out_ready = 1'b1; step();
      checks++; if (out_data !== 32'hB || in_ready !== 1'b1)
         begin errors++; $display("FAIL bp_pop_a got r=%b %h exp r=1 b", in_ready, out_data); end
      step();
      checks++; if (out_data !== 32'hC || out_valid !== 1'b1)
         begin errors++; $display("FAIL bp_pop_b got v=%b %h exp v=1 c", out_valid, out_data); end
      in_valid = 1'b0; step();
      checks++; if (out_valid !== 1'b0)
         begin errors++; $display("FAIL bp_drain got %b exp 0", out_valid); end
   endtask

   task automatic test_stream();
      logic [31:0] exp_q[$];
      logic [31:0] d, e;
      logic [SEL_W-1:0] s;
      int pushed = 0;
      int cyc = 0;
      logic do_push, do_pop;
      while ((pushed < 100 || exp_q.size() != 0) && cyc < 3000) begin
         in_valid = 1'b0;
         if (pushed < 100 && $urandom_range(0, 3) != 0) begin
            s = ($urandom_range(0, 6) == 0) ? 3'd0 : SEL_W'($urandom_range(2, 7));
            d = $urandom;
            drive(s, d, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            e = (int'(s) >= NUM_IN) ? 32'd277 : d;
         end else begin
            sel = SEL_W'($urandom_range(0, 7));
            e = 32'h0;
         end
         out_ready = (pushed >= 100) ? 1'b1 : 1'($urandom_range(0, 1));
         checks++;
         if (in_ready !== (exp_q.size() != 2) || out_valid !== (exp_q.size() != 0)) begin
            errors++;
            $display("FAIL stream_flags cyc %0d got r=%b v=%b exp occ=%0d", cyc, in_ready, out_valid, exp_q.size());
         end
         do_push = in_valid && (exp_q.size() < 2);
         do_pop  = out_ready && (exp_q.size() > 0);
         if (do_pop) begin
            checks++;
            if (out_data !== exp_q[0] || out_err !== 1'b0) begin
               errors++;
               $display("FAIL stream_data cyc %0d got %h/%b exp %h/0", cyc, out_data, out_err, exp_q[0]);
            end
            void'(exp_q.pop_front());
         end
         if (do_push) begin
            exp_q.push_back(e);
            pushed++;
         end
         step();
         cyc++;
      end
      in_valid = 1'b0;
      checks++;
      if (cyc >= 3000) begin errors++; $display("FAIL stream_timeout got %0d pushed exp 100 drained", pushed); end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      drive(3'd4, 32'h1111_1111, 2'b00, 1'b0, 2'b00); step();
      drive(3'd4, 32'h2222_2222, 2'b00, 1'b0, 2'b00); step();
      in_valid = 1'b0;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_two got r=%b exp 0", in_ready); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0)
         begin errors++; $display("FAIL mid_async got v=%b r=%b %h exp v=0 r=1 0", out_valid, in_ready, out_data); end
      step();
      #3 rst_n = 1'b1;
      out_ready = 1'b1;
      drive(3'd4, 32'h3333_3333, 2'b00, 1'b0, 2'b00); step();
      checks++; if (out_valid !== 1'b1 || out_data !== 32'h3333_3333)
         begin errors++; $display("FAIL mid_new got v=%b %h exp v=1 33333333", out_valid, out_data); end
      in_valid = 1'b0; step();
      checks++; if (out_valid !== 1'b0)
         begin errors++; $display("FAIL mid_no_stale got v=%b %h exp v=0", out_valid, out_data); end
   endtask

   initial begin
      test_reset();
      test_select();
      test_extract();
      test_back_to_back();
      test_stream();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
